data_mem_responder: RTL



---
 rtl/data_mem_responder_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 50 +++++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage load/store responder: access sizes,
// FSM state encoding and the captured request record.
package data_mem_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts and extends load data, merges store
// data into the old word, and flags misaligned or reserved-size accesses.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o,
  output logic        misalign_o
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_shift = {addr_lo_i, 3'b000};
    half_shift = {addr_lo_i[1], 4'b0000};
    byte_sel   = 8'(word_i >> byte_shift);
    half_sel   = 16'(word_i >> half_shift);
    load_o     = '0;
    store_o    = word_i;
    misalign_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        load_o  = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
        store_o = (word_i & ~(32'h0000_00FF << byte_shift)) |
                  (32'(wdata_i[7:0]) << byte_shift);
      end
      SIZE_HALF: begin
        misalign_o = addr_lo_i[0];
        load_o     = {{16{sign_ext_i & half_sel[15]}}, half_sel};
        store_o    = (word_i & ~(32'h0000_FFFF << half_shift)) |
                     (32'(wdata_i[15:0]) << half_shift);
      end
      SIZE_WORD: begin
        misalign_o = (addr_lo_i != 2'b00);
        load_o     = word_i;
        store_o    = wdata_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: one outstanding access at a time into local
// word storage, answered a fixed LATENCY after acceptance, with pipeline Stall.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSignExt,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        ReqReady,
  output logic        RespValid,
  output logic [31:0] RespRData,
  output logic        RespErr,
  output logic        Stall
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e           state_q, state_d;
  logic [3:0]       count_q, count_d;
  mem_req_t         req_q, req_d, req_eff;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      rd_word, load_val, store_word;
  logic             misalign, out_of_range, req_err, enter_resp, mem_we;

  // With LATENCY=1 the access completes on the accept edge itself, before the
  // request registers are loaded, so the live inputs are used while IDLE.
  always_comb begin
    req_eff = (state_q == ST_IDLE) ? mem_req_t'{ReqWrite, ReqSize, ReqSignExt, ReqAddr, ReqWData}
                                   : req_q;
    mem_idx      = req_eff.addr[2 +: IDX_W];
    rd_word      = mem_q[mem_idx];
    out_of_range = {2'b00, req_eff.addr[31:2]} >= 32'(DEPTH_WORDS);
    req_err      = misalign | out_of_range;
  end

  mem_lane_align u_align (
    .word_i     (rd_word),
    .addr_lo_i  (req_eff.addr[1:0]),
    .size_i     (req_eff.size),
    .sign_ext_i (req_eff.sign_ext),
    .wdata_i    (req_eff.wdata),
    .load_o     (load_val),
    .store_o    (store_word),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          req_d = req_eff;
          if (LATENCY == 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_BUSY;
            count_d = 4'(LATENCY - 1);
          end
        end
      end
      ST_BUSY: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = req_err;
      rdata_d = (req_err || req_eff.write) ? 32'h0 : load_val;
    end
    // A store aborted by Reset on its commit edge must never reach storage.
    mem_we = enter_resp & req_eff.write & ~req_err & ~Reset;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[mem_idx] <= store_word;
  end

  always_comb begin
    ReqReady  = (state_q == ST_IDLE);
    RespValid = (state_q == ST_RESP);
    RespRData = RespValid ? rdata_q : 32'h0;
    RespErr   = RespValid & err_q;
    Stall     = ((state_q == ST_IDLE) & ReqValid) | (state_q == ST_BUSY);
  end

endmodule
